// File: rtl/cmv300_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmv300_pkg
// Purpose  : State encoding, default frame geometry and helpers shared by the
//            CMV300 frame grabber.
// Revision : 1.0
// ============================================================================
package cmv300_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DELAY   = 3'd1;
   localparam logic [2:0] ST_REQ     = 3'd2;
   localparam logic [2:0] ST_WAIT    = 3'd3;
   localparam logic [2:0] ST_CAPTURE = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_DELAY   = ST_DELAY,
      S_REQ     = ST_REQ,
      S_WAIT    = ST_WAIT,
      S_CAPTURE = ST_CAPTURE,
      S_DONE    = ST_DONE
   } state_t;

   localparam int FRAME_COLS           = 648;
   localparam int FRAME_ROWS           = 488;
   localparam int DEF_PIXELS_PER_FRAME = FRAME_COLS * FRAME_ROWS;
   localparam int DEF_REQ_DELAY        = 16;
   localparam int DEF_REQ_WIDTH        = 1;
   localparam int DEF_TIMEOUT_CYCLES   = 2**20;
   localparam int PIXEL_COUNT_W        = 20;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cmv300_frame_grabber_if.sv
`default_nettype none
// ============================================================================
// Module   : cmv300_frame_grabber_if
// Purpose  : Command, sensor and FIFO-write signals of the frame grabber.
// Revision : 1.0
// ============================================================================
interface cmv300_frame_grabber_if;

   logic                               start;
   logic                               abort;
   logic [9:0]                         CVM300_D;
   logic                               CVM300_Data_valid;
   logic                               CVM300_FRAME_REQ;
   logic                               fifo_full;
   logic [31:0]                        fifo_din;
   logic                               fifo_wr_en;
   logic                               busy;
   logic                               frame_done;
   logic                               overflow;
   logic                               timeout;
   logic [cmv300_pkg::PIXEL_COUNT_W-1:0] pixel_count;

   // The grabber sits on the slave side; the master issues commands and sees status.
   modport slave (
      input  start, abort, CVM300_D, CVM300_Data_valid, fifo_full,
      output CVM300_FRAME_REQ, fifo_din, fifo_wr_en, busy, frame_done,
             overflow, timeout, pixel_count
   );

   modport master (
      output start, abort, CVM300_D, CVM300_Data_valid, fifo_full,
      input  CVM300_FRAME_REQ, fifo_din, fifo_wr_en, busy, frame_done,
             overflow, timeout, pixel_count
   );

endinterface
`default_nettype wire

// File: rtl/pixel_packer_8to32.sv
`default_nettype none
// ============================================================================
// Module   : pixel_packer_8to32
// Purpose  : Packs four 8-bit pixels into a 32-bit word, first pixel in the MSB.
// Revision : 1.0
// ============================================================================
module pixel_packer_8to32 (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        i_clear,
   input  wire logic        i_valid,
   input  wire logic [7:0]  i_pixel,
   output logic      [31:0] o_word,
   output logic             o_word_valid
);

   logic [31:0] r_shift;
   logic [1:0]  r_idx;
   logic        r_word_valid;

   // The word stays stable during its valid cycle: a new pixel only shifts in at the closing edge.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_shift      <= 32'd0;
         r_idx        <= 2'd0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= i_valid && (r_idx == 2'd3);
         if (i_valid) begin
            r_shift <= {r_shift[23:0], i_pixel};
            r_idx   <= r_idx + 2'd1;
         end
      end
   end

   assign o_word       = r_shift;
   assign o_word_valid = r_word_valid;

endmodule
`default_nettype wire

// File: rtl/cmv300_frame_grabber.sv
`default_nettype none
// ============================================================================
// Module   : cmv300_frame_grabber
// Purpose  : Requests one CMV300 frame, packs pixels D[9:2] into 32-bit words
//            and writes them into the readout FIFO.
// Revision : 1.0
// ============================================================================
module cmv300_frame_grabber
   import cmv300_pkg::*;
#(
   parameter int PIXELS_PER_FRAME = DEF_PIXELS_PER_FRAME,
   parameter int REQ_DELAY        = DEF_REQ_DELAY,
   parameter int REQ_WIDTH        = DEF_REQ_WIDTH,
   parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
   input  wire logic             FSM_Clk,
   input  wire logic             Reset,
   cmv300_frame_grabber_if.slave grab
);

   localparam int CNT_W = $clog2(max3(REQ_DELAY, REQ_WIDTH, TIMEOUT_CYCLES) + 1);
   localparam logic [CNT_W-1:0]         c_delay_last = CNT_W'(REQ_DELAY - 1);
   localparam logic [CNT_W-1:0]         c_req_last   = CNT_W'(REQ_WIDTH - 1);
   localparam logic [CNT_W-1:0]         c_to_last    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PIXEL_COUNT_W-1:0] c_last_pix   = PIXEL_COUNT_W'(PIXELS_PER_FRAME - 1);
   localparam logic [PIXEL_COUNT_W-1:0] c_frame_pix  = PIXEL_COUNT_W'(PIXELS_PER_FRAME);

   state_t                   r_state;
   state_t                   w_next;
   logic [CNT_W-1:0]         r_cnt;
   logic [PIXEL_COUNT_W-1:0] r_pix_cnt;
   logic                     r_frame_req;
   logic                     r_overflow;
   logic                     r_timeout;
   logic                     w_cnt_clr;
   logic                     w_cnt_inc;
   logic                     w_capture;
   logic                     w_set_timeout;
   logic                     w_start_ok;
   logic                     w_pk_clear;
   logic [31:0]              w_word;
   logic                     w_word_valid;
   logic [7:0]               w_pixel;
   logic                     w_unused_lsbs;

   assign w_pixel       = grab.CVM300_D[9:2];
   assign w_unused_lsbs = ^grab.CVM300_D[1:0];

   always_ff @(posedge FSM_Clk) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      w_cnt_clr     = 1'b0;
      w_cnt_inc     = 1'b0;
      w_capture     = 1'b0;
      w_set_timeout = 1'b0;
      w_start_ok    = 1'b0;
      w_pk_clear    = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (grab.start) begin
               w_next     = S_DELAY;
               w_start_ok = 1'b1;
               w_cnt_clr  = 1'b1;
               w_pk_clear = 1'b1;
            end
         end
         S_DELAY: begin
            if (r_cnt == c_delay_last) begin
               w_next    = S_REQ;
               w_cnt_clr = 1'b1;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_REQ: begin
            if (r_cnt == c_req_last) begin
               w_next    = S_WAIT;
               w_cnt_clr = 1'b1;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         // The counter measures the idle run since REQ ended or since the last pixel.
         S_WAIT, S_CAPTURE: begin
            if (grab.CVM300_Data_valid) begin
               w_capture = 1'b1;
               w_cnt_clr = 1'b1;
               w_next    = (r_pix_cnt == c_last_pix) ? S_DONE : S_CAPTURE;
            end else if (r_cnt == c_to_last) begin
               w_set_timeout = 1'b1;
               w_pk_clear    = 1'b1;
               w_next        = S_IDLE;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase

      if (grab.abort && (r_state != S_IDLE)) begin
         w_next        = S_IDLE;
         w_capture     = 1'b0;
         w_set_timeout = 1'b0;
         w_start_ok    = 1'b0;
         w_cnt_inc     = 1'b0;
         w_cnt_clr     = 1'b1;
         w_pk_clear    = 1'b1;
      end
   end

   always_ff @(posedge FSM_Clk) begin
      if (Reset) begin
         r_cnt       <= '0;
         r_pix_cnt   <= '0;
         r_frame_req <= 1'b0;
         r_overflow  <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;

         if (w_start_ok)                                r_pix_cnt <= '0;
         else if (w_capture && (r_pix_cnt != c_frame_pix)) r_pix_cnt <= r_pix_cnt + 1'b1;

         r_frame_req <= (w_next == S_REQ);

         if (w_start_ok) begin
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
         end else begin
            if (w_word_valid && grab.fifo_full) r_overflow <= 1'b1;
            if (w_set_timeout)                  r_timeout  <= 1'b1;
         end
      end
   end

   pixel_packer_8to32 u_packer (
      .clk          (FSM_Clk),
      .rst          (Reset),
      .i_clear      (w_pk_clear),
      .i_valid      (w_capture),
      .i_pixel      (w_pixel),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   // A completed word is written one cycle after its 4th pixel, unless the FIFO is full.
   assign grab.fifo_wr_en       = w_word_valid & ~grab.fifo_full & ~Reset;
   assign grab.frame_done       = w_word_valid & (r_state == S_DONE) & ~Reset;
   assign grab.fifo_din         = w_word;
   assign grab.CVM300_FRAME_REQ = r_frame_req;
   assign grab.busy             = (r_state != S_IDLE) && (r_state != S_DONE);
   assign grab.overflow         = r_overflow;
   assign grab.timeout          = r_timeout;
   assign grab.pixel_count      = r_pix_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cmv300_frame_grabber.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmv300_frame_grabber
// Purpose  : Directed self-checking bench for cmv300_frame_grabber.
// Revision : 1.0
// ============================================================================
module tb_cmv300_frame_grabber;

   localparam int P_PPF   = 8;
   localparam int P_DELAY = 5;
   localparam int P_WIDTH = 2;
   localparam int P_TO    = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   cmv300_frame_grabber_if bus_if ();

   cmv300_frame_grabber #(
      .PIXELS_PER_FRAME (P_PPF),
      .REQ_DELAY        (P_DELAY),
      .REQ_WIDTH        (P_WIDTH),
      .TIMEOUT_CYCLES   (P_TO)
   ) dut (
      .FSM_Clk (clk),
      .Reset   (rst),
      .grab    (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame-level model: request window and timeout deadline derived from the start edge.
   bit          m_busy, m_pend, m_last, m_ovf, m_to;
   int          m_count, m_ref, m_req_lo, m_req_hi;
   logic [7:0]  m_bytes[$];
   logic [31:0] m_word;

   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_busy = 0; m_pend = 0; m_last = 0; m_ovf = 0; m_to = 0;
         m_count = 0; m_req_lo = -10; m_req_hi = -10; m_ref = 0;
         m_bytes.delete();
      end else begin
         if (m_pend && bus_if.fifo_full) m_ovf = 1;
         m_pend = 0;
         m_last = 0;
         if (m_busy && bus_if.abort) begin
            m_busy = 0;
            m_bytes.delete();
         end else if (!m_busy && bus_if.start) begin
            m_busy = 1; m_count = 0; m_ovf = 0; m_to = 0;
            m_bytes.delete();
            m_req_lo = cyc + P_DELAY;
            m_req_hi = cyc + P_DELAY + P_WIDTH - 1;
            m_ref    = cyc + P_DELAY + P_WIDTH;
         end else if (m_busy && cyc > m_ref) begin
            if (bus_if.CVM300_Data_valid) begin
               m_bytes.push_back(bus_if.CVM300_D[9:2]);
               m_count++;
               m_ref = cyc;
               if (m_bytes.size() == 4) begin
                  m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                  m_pend = 1;
                  m_bytes.delete();
               end
               if (m_count == P_PPF) begin
                  m_busy = 0;
                  m_last = m_pend;
               end
            end else if (cyc == m_ref + P_TO) begin
               m_to = 1;
               m_busy = 0;
               m_bytes.delete();
            end
         end
      end
   end

   logic [31:0] got[$];
   int          n_done, req_rise, req_len, to_rise;
   bit          prev_req, prev_to;

   initial forever begin
      @(negedge clk);
      if (cyc > 0) begin
         chk("frame_req",   bus_if.CVM300_FRAME_REQ,
             m_busy && cyc >= m_req_lo && cyc <= m_req_hi);
         chk("busy",        bus_if.busy, m_busy);
         chk("wr_en",       bus_if.fifo_wr_en, m_pend && !bus_if.fifo_full && !rst);
         if (m_pend && !bus_if.fifo_full && !rst) chk("din", bus_if.fifo_din, m_word);
         chk("frame_done",  bus_if.frame_done, m_pend && m_last && !rst);
         chk("overflow",    bus_if.overflow, m_ovf);
         chk("timeout",     bus_if.timeout, m_to);
         chk("pixel_count", bus_if.pixel_count, m_count);
         if (bus_if.fifo_wr_en === 1'b1) got.push_back(bus_if.fifo_din);
         if (bus_if.frame_done === 1'b1) n_done++;
         if (bus_if.CVM300_FRAME_REQ === 1'b1) begin
            if (!prev_req) req_rise = cyc;
            req_len++;
         end
         if (bus_if.timeout === 1'b1 && !prev_to) to_rise = cyc;
         prev_req = (bus_if.CVM300_FRAME_REQ === 1'b1);
         prev_to  = (bus_if.timeout === 1'b1);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int t0;

   task automatic do_start();
      bus_if.start = 1'b1;
      tick(1);
      bus_if.start = 1'b0;
      t0 = cyc;
   endtask

   task automatic pix(input logic [9:0] d);
      bus_if.CVM300_D          = d;
      bus_if.CVM300_Data_valid = 1'b1;
      tick(1);
      bus_if.CVM300_Data_valid = 1'b0;
   endtask

   task automatic clear_obs();
      got.delete();
      n_done = 0; req_len = 0; req_rise = -1; to_rise = -1;
   endtask

   initial begin
      bus_if.start = 1'b0; bus_if.abort = 1'b0; bus_if.CVM300_D = 10'd0;
      bus_if.CVM300_Data_valid = 1'b0; bus_if.fifo_full = 1'b0;
      clear_obs();
      tick(3);
      rst = 1'b0;
      tick(2);
      chk("rst_busy",  bus_if.busy, 1'b0);
      chk("rst_count", bus_if.pixel_count, 32'd0);

      // Basic frame of 8 pixels, plus one stray pixel after the frame
      clear_obs();
      do_start();
      tick(P_DELAY + P_WIDTH + 2);
      for (int i = 1; i <= 8; i++) pix(10'(i * 4));
      pix(10'h3FC);
      tick(3);
      chk("s1_nwords",   got.size(), 32'd2);
      chk("s1_word0",    got[0], 32'h01020304);
      chk("s1_word1",    got[1], 32'h05060708);
      chk("s1_ndone",    n_done, 32'd1);
      chk("s1_busy",     bus_if.busy, 1'b0);
      chk("s1_count",    bus_if.pixel_count, 32'd8);
      chk("s2_req_rise", req_rise - t0, 32'd5);
      chk("s2_req_len",  req_len, 32'd2);

      // Valid toggling every cycle; a start during capture is ignored
      clear_obs();
      do_start();
      tick(P_DELAY + P_WIDTH);
      for (int i = 1; i <= 8; i++) begin
         pix({8'(i), 2'b11});
         if (i == 3) bus_if.start = 1'b1;
         tick(1);
         bus_if.start = 1'b0;
      end
      tick(3);
      chk("s3_nwords",  got.size(), 32'd2);
      chk("s3_word0",   got[0], 32'h01020304);
      chk("s3_word1",   got[1], 32'h05060708);
      chk("s3_timeout", bus_if.timeout, 1'b0);
      chk("s3_ndone",   n_done, 32'd1);

      // FIFO full during the second word's write cycle
      clear_obs();
      do_start();
      tick(P_DELAY + P_WIDTH + 1);
      for (int i = 1; i <= 8; i++) begin
         if (i >= 6) bus_if.fifo_full = 1'b1;
         pix({8'(i), 2'b10});
      end
      tick(1);
      bus_if.fifo_full = 1'b0;
      tick(4);
      chk("s4_nwords",   got.size(), 32'd1);
      chk("s4_word0",    got[0], 32'h01020304);
      chk("s4_overflow", bus_if.overflow, 1'b1);
      chk("s4_ndone",    n_done, 32'd1);

      // Sensor silent after the request
      clear_obs();
      do_start();
      tick(1);
      chk("s5_ovf_clr", bus_if.overflow, 1'b0);
      tick(P_DELAY + P_WIDTH + 40);
      chk("s5_to_rise", to_rise - t0, 32'd39);
      chk("s5_timeout", bus_if.timeout, 1'b1);
      chk("s5_busy",    bus_if.busy, 1'b0);
      chk("s5_nwords",  got.size(), 32'd0);

      // Abort after three pixels, then a fresh frame
      clear_obs();
      do_start();
      tick(P_DELAY + P_WIDTH);
      pix(10'h2A8); pix(10'h2EC); pix(10'h330);
      bus_if.abort = 1'b1;
      tick(1);
      bus_if.abort = 1'b0;
      tick(2);
      chk("s6_busy", bus_if.busy, 1'b0);
      do_start();
      tick(P_DELAY + P_WIDTH);
      for (int i = 1; i <= 8; i++) pix({8'(i * 17), 2'b01});
      tick(3);
      chk("s6_nwords", got.size(), 32'd2);
      chk("s6_word0",  got[0], 32'h11223344);
      chk("s6_word1",  got[1], 32'h55667788);

      // Reset asserted in the write cycle of a completed word
      clear_obs();
      do_start();
      tick(P_DELAY + P_WIDTH);
      for (int i = 1; i <= 4; i++) pix({8'(i), 2'b00});
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(2);
      chk("s7_nwords", got.size(), 32'd0);
      chk("s7_busy",   bus_if.busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
